// File: rtl/booth_mult.sv
// Radix-2 Booth signed 32x32 multiplier: one iteration per clock, 32 iterations per product.
// Handshake: workMult is a start request honoured only in IDLE; endMult pulses one cycle when mul is fresh.
module booth_mult (
  input  logic        Clk,
  input  logic        reset,
  input  logic        workMult,
  input  logic [31:0] oper_A,
  input  logic [31:0] oper_B,
  output logic [63:0] mul,
  output logic        endMult,
  output logic        busy,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [32:0] r_m;
  logic [32:0] r_acc;
  logic [31:0] r_q;
  logic        r_q_m1;
  logic [5:0]  r_count;
  logic [63:0] r_mul;
  logic        r_end;
  logic        r_busy;

  logic [32:0] w_sum;
  logic [32:0] w_acc_next;
  logic [31:0] w_q_next;
  logic        w_last;

  // Accumulator is 33 bits so subtracting the most negative M cannot overflow.
  always_comb begin
    w_sum = r_acc;
    unique case ({r_q[0], r_q_m1})
      2'b01:   w_sum = r_acc + r_m;
      2'b10:   w_sum = r_acc - r_m;
      default: w_sum = r_acc;
    endcase
  end

  assign w_acc_next = {w_sum[32], w_sum[32:1]};
  assign w_q_next   = {w_sum[0], r_q[31:1]};
  assign w_last     = (r_count == 6'd31);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_q_m1  <= 1'b0;
      r_count <= '0;
      r_mul   <= '0;
      r_end   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_end <= 1'b0;
          if (workMult) begin
            r_m     <= {oper_A[31], oper_A};
            r_q     <= oper_B;
            r_acc   <= '0;
            r_q_m1  <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_q     <= w_q_next;
          r_q_m1  <= r_q[0];
          r_count <= r_count + 6'd1;
          // Product is published on the same edge as the 32nd iteration.
          if (w_last) begin
            r_mul   <= {w_acc_next[31:0], w_q_next};
            r_end   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_end   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_end   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mul         = r_mul;
  assign endMult     = r_end;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_booth_mult.sv
// Bench for booth_mult: directed vector table, latency/abort/overlap sequences and a random back-to-back run.
module tb_booth_mult;

  logic        Clk;
  logic        reset;
  logic        workMult;
  logic [31:0] oper_A;
  logic [31:0] oper_B;
  logic [63:0] mul;
  logic        endMult;
  logic        busy;
  logic [1:0]  dbg_state;

  booth_mult dut (
    .Clk        (Clk),
    .reset      (reset),
    .workMult   (workMult),
    .oper_A     (oper_A),
    .oper_B     (oper_B),
    .mul        (mul),
    .endMult    (endMult),
    .busy       (busy),
    .o_dbg_state(dbg_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  logic [63:0] exp_q[$];
  int          checks;
  int          errors;
  int          n_end;
  int          n_exp;
  logic [63:0] prev_mul;
  logic        prev_end;
  logic        stop_mon;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  function automatic logic [31:0] rand_op();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, act, req, $time);
    end
  endtask

  // Single-cycle start pulse; returns just after the start edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    @(negedge Clk);
    oper_A   = a;
    oper_B   = b;
    workMult = 1'b1;
    exp_q.push_back(exp);
    n_exp++;
    @(posedge Clk);
    #1;
    workMult = 1'b0;
    oper_A   = $urandom();
    oper_B   = $urandom();
  endtask

  // Start, then check endMult timing edge by edge and the product at completion.
  task automatic run_checked(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp);
    start_op(a, b, exp);
    for (int j = 0; j <= 33; j++) begin
      @(negedge Clk);
      if (j == 0) check1({name, "_busy_run"}, busy, 1'b1);
      if (j == 31) check1({name, "_end_early"}, endMult, 1'b0);
      if (j == 32) begin
        check1({name, "_end_pulse"}, endMult, 1'b1);
        check64({name, "_mul"}, mul, exp);
      end
      if (j == 33) begin
        check1({name, "_end_low"}, endMult, 1'b0);
        check1({name, "_busy_low"}, busy, 1'b0);
      end
    end
  endtask

  task automatic monitor_step();
    logic [63:0] e;
    if (reset) begin
      if (endMult) begin
        n_end++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_end got mul %h want no pulse at %0t", mul, $time);
        end else begin
          e = exp_q.pop_front();
          check64("sb_mul", mul, e);
        end
        if (prev_end) check1("sb_end_width", prev_end, 1'b0);
      end
      if (busy && !endMult) check64("sb_mul_stable", mul, prev_mul);
    end
    prev_mul = mul;
    prev_end = endMult;
  endtask

  vec_t vecs[8];

  initial begin
    int base_end;
    int cnt;
    bit seen;
    checks   = 0;
    errors   = 0;
    n_end    = 0;
    n_exp    = 0;
    prev_mul = '0;
    prev_end = 1'b0;
    stop_mon = 1'b0;
    reset    = 1'b0;
    workMult = 1'b0;
    oper_A   = '0;
    oper_B   = '0;

    vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF,  32'h0000_0001,  64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
    vecs[3] = '{32'h7FFF_FFFF,  32'h8000_0000,  64'hC000_0000_8000_0000};
    vecs[4] = '{32'h0000_0000,  32'h1234_5678,  64'h0000_0000_0000_0000};
    vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001};
    vecs[6] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001};
    vecs[7] = '{32'hFFFF_FFFE,  32'h0000_0064,  64'hFFFF_FFFF_FFFF_FF38};

    fork
      begin
        forever begin
          @(negedge Clk);
          if (stop_mon) break;
          monitor_step();
        end
      end
      begin
        // Reset state
        #12;
        check64("rst_mul", mul, 64'h0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_end", endMult, 1'b0);
        @(negedge Clk);
        reset = 1'b1;
        repeat (2) @(negedge Clk);

        foreach (vecs[i]) run_checked($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);

        // Held request with operands changed mid-run: one product per accepted start
        @(negedge Clk);
        oper_A   = 32'd3;
        oper_B   = 32'd5;
        workMult = 1'b1;
        exp_q.push_back(64'h0F);
        n_exp++;
        @(negedge Clk);
        oper_A = 32'd7;
        oper_B = 32'd7;
        base_end = n_end;
        cnt = 0;
        while (n_end == base_end && cnt < 60) begin
          @(negedge Clk);
          cnt++;
        end
        check1("hold_first_done", (n_end == base_end + 1), 1'b1);
        exp_q.push_back(64'h31);
        n_exp++;
        cnt = 0;
        while (n_end == base_end + 1 && cnt < 60) begin
          @(negedge Clk);
          cnt++;
        end
        workMult = 1'b0;
        check1("hold_second_done", (n_end == base_end + 2), 1'b1);
        check1("hold_restart_gap", (cnt >= 33), 1'b1);
        check64("hold_mul", mul, 64'h31);
        repeat (3) @(negedge Clk);

        // Abort mid-run by reset
        start_op(32'd3, 32'd5, 64'h0F);
        repeat (10) @(posedge Clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        n_exp--;
        #1;
        check64("abort_mul", mul, 64'h0);
        check1("abort_busy", busy, 1'b0);
        check1("abort_end", endMult, 1'b0);
        base_end = n_end;
        repeat (2) @(negedge Clk);
        reset = 1'b1;
        repeat (40) @(negedge Clk);
        check1("abort_no_end", (n_end == base_end), 1'b1);
        run_checked("post_rst", 32'd2, 32'd2, 64'h4);

        // Random back-to-back starts with operands scrambled during each run
        workMult = 1'b1;
        for (int i = 0; i < 1000; i++) begin
          logic [31:0] a;
          logic [31:0] b;
          a = rand_op();
          b = rand_op();
          oper_A = a;
          oper_B = b;
          exp_q.push_back(ref_prod(a, b));
          n_exp++;
          seen = 1'b0;
          for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (!busy) begin
              seen = 1'b1;
              break;
            end
            oper_A = $urandom();
            oper_B = $urandom();
          end
          if (!seen) begin
            check1("rand_timeout", 1'b0, 1'b1);
            break;
          end
        end
        workMult = 1'b0;
        repeat (40) @(negedge Clk);

        check1("end_count", (n_end == n_exp), 1'b1);
        check1("queue_empty", (exp_q.size() == 0), 1'b1);
        stop_mon = 1'b1;
        @(negedge Clk);
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
